// File: rtl/ped_crossing_controller.sv
// Pedestrian crossing controller: grants WALK/flash DON'T-WALK inside a vehicle RED phase,
// latching button requests and aborting to DON'T-WALK as soon as RED ends.
module ped_crossing_controller #(
  parameter int unsigned WALK_CYCLES  = 3,
  parameter int unsigned FLASH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       flash,
  output logic       req_pending,
  output logic [3:0] countdown,
  output logic       fault
);

  typedef enum logic [1:0] {StStop, StWalk, StFlash} state_e;

  localparam logic [2:0] LightRed = 3'b100;
  localparam logic [3:0] TotalCnt = 4'(WALK_CYCLES + FLASH_CYCLES);
  localparam logic [3:0] FlashCnt = 4'(FLASH_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] light_q;
  logic       btn_q;
  logic       req_q, req_d;
  logic       fault_q;

  logic light_valid, is_red, red_rise, btn_rise;

  always_comb begin
    light_valid = (light == 3'b100) || (light == 3'b010) || (light == 3'b001);
    is_red      = (light == LightRed);
    red_rise    = is_red && (light_q != LightRed);
    btn_rise    = ped_btn && !btn_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q | btn_rise;
    if (!light_valid) begin
      state_d = StStop;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        StStop: begin
          cnt_d = 4'd0;
          // A press arriving on the same edge as RED entry is consumed by this crossing.
          if (red_rise && (req_q || btn_rise)) begin
            state_d = StWalk;
            cnt_d   = TotalCnt;
            req_d   = 1'b0;
          end
        end
        StWalk: begin
          if (!is_red) begin
            state_d = StStop;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == FlashCnt + 4'd1) state_d = StFlash;
          end
        end
        StFlash: begin
          if (!is_red || (cnt_q == 4'd1)) begin
            state_d = StStop;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = StStop;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StStop;
      cnt_q   <= 4'd0;
      light_q <= 3'b000;
      btn_q   <= 1'b0;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      light_q <= light;
      btn_q   <= ped_btn;
      req_q   <= req_d;
      fault_q <= !light_valid;
    end
  end

  // In FLASH the lamp is lit when the counter has the parity of the first FLASH cycle.
  always_comb begin
    walk        = (state_q == StWalk);
    flash       = (state_q == StFlash);
    dont_walk   = 1'b0;
    if (state_q == StStop) dont_walk = 1'b1;
    else if (state_q == StFlash) dont_walk = (cnt_q[0] == FlashCnt[0]);
    req_pending = req_q;
    countdown   = cnt_q;
    fault       = fault_q;
  end

endmodule

// File: tb/tb_ped_crossing_controller.sv
// Directed-vector bench for ped_crossing_controller with default timing (3 WALK, 2 FLASH).
module tb_ped_crossing_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] light;
  logic       ped_btn;
  logic       walk, dont_walk, flash, req_pending, fault;
  logic [3:0] countdown;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  ped_crossing_controller #(
    .WALK_CYCLES (3),
    .FLASH_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .light      (light),
    .ped_btn    (ped_btn),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .flash      (flash),
    .req_pending(req_pending),
    .countdown  (countdown),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Packed as {walk, dont_walk, flash, req_pending, fault, countdown}.
  function automatic logic [8:0] ev(input logic w, input logic dw, input logic f,
                                    input logic r, input logic flt, input logic [3:0] c);
    return {w, dw, f, r, flt, c};
  endfunction

  task automatic check_eq(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got w/dw/f/req/flt/cnt=%b required %b", tag, got, exp);
  endtask

  // Drive one cycle of inputs, then check the outputs of the following cycle.
  task automatic vec(input string tag, input logic r, input logic [2:0] l, input logic b,
                     input logic [8:0] exp);
    rst     = r;
    light   = l;
    ped_btn = b;
    @(posedge clk);
    #1;
    check_eq(tag, {walk, dont_walk, flash, req_pending, fault, countdown}, exp);
  endtask

  task automatic vec_n(input string tag, input int n, input logic r, input logic [2:0] l,
                       input logic b, input logic [8:0] exp);
    for (int i = 0; i < n; i++) vec(tag, r, l, b, exp);
  endtask

  logic [8:0] s_idle, s_req;

  initial begin
    s_idle  = ev(0, 1, 0, 0, 0, 4'd0);
    s_req   = ev(0, 1, 0, 1, 0, 4'd0);
    rst     = 1'b1;
    light   = G;
    ped_btn = 1'b0;

    vec_n("reset", 2, 1, G, 0, s_idle);
    vec_n("idle", 3, 0, G, 0, s_idle);

    // Single press, crossing at the next RED entry.
    vec("a_press", 0, G, 1, s_req);
    vec_n("a_pending", 7, 0, G, 0, s_req);
    vec("a_walk5", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd5));
    vec("a_walk4", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd4));
    vec("a_walk3", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd3));
    vec("a_flash2", 0, R, 0, ev(0, 1, 1, 0, 0, 4'd2));
    vec("a_flash1", 0, R, 0, ev(0, 0, 1, 0, 0, 4'd1));
    vec("a_stop", 0, R, 0, s_idle);
    vec("a_yellow", 0, Y, 0, s_idle);
    vec("a_green", 0, G, 0, s_idle);

    // Held button across two RED phases: one crossing only.
    vec_n("b_held", 2, 0, G, 1, s_req);
    vec("b_walk5", 0, R, 1, ev(1, 0, 0, 0, 0, 4'd5));
    vec("b_walk4", 0, R, 1, ev(1, 0, 0, 0, 0, 4'd4));
    vec("b_walk3", 0, R, 1, ev(1, 0, 0, 0, 0, 4'd3));
    vec("b_flash2", 0, R, 1, ev(0, 1, 1, 0, 0, 4'd2));
    vec("b_flash1", 0, R, 1, ev(0, 0, 1, 0, 0, 4'd1));
    vec("b_stop", 0, R, 1, s_idle);
    vec("b_yellow", 0, Y, 1, s_idle);
    vec_n("b_green", 2, 0, G, 1, s_idle);
    vec_n("b_red2", 4, 0, R, 1, s_idle);
    vec_n("b_yellow2", 2, 0, Y, 1, s_idle);
    vec_n("b_green2", 3, 0, G, 1, s_idle);
    vec("b_release", 0, G, 0, s_idle);

    // Abort from WALK when RED ends.
    vec("c_press", 0, G, 1, s_req);
    vec("c_pending", 0, G, 0, s_req);
    vec("c_walk5", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd5));
    vec("c_walk4", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd4));
    vec("c_abort", 0, G, 0, s_idle);
    vec("c_after", 0, G, 0, s_idle);

    // Press during FLASH waits for the next RED entry.
    vec("d_press", 0, G, 1, s_req);
    vec("d_pending", 0, G, 0, s_req);
    vec("d_walk5", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd5));
    vec("d_walk4", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd4));
    vec("d_walk3", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd3));
    vec("d_flash2", 0, R, 0, ev(0, 1, 1, 0, 0, 4'd2));
    vec("d_flash_press", 0, R, 1, ev(0, 0, 1, 1, 0, 4'd1));
    vec("d_stop_req", 0, R, 0, s_req);
    vec("d_no_retrig", 0, R, 0, s_req);
    vec_n("d_yellow", 2, 0, Y, 0, s_req);
    vec_n("d_green", 2, 0, G, 0, s_req);
    vec("d_served", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd5));
    vec("d_abort", 0, G, 0, s_idle);

    // Press on the RED-entry edge is consumed without leaving a request.
    vec("e_green", 0, G, 0, s_idle);
    vec("e_same_edge", 0, R, 1, ev(1, 0, 0, 0, 0, 4'd5));
    vec("e_walk4", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd4));

    // Invalid code mid-WALK: fault follows validity with one-cycle lag, state to STOP.
    vec("f_bad1", 0, 3'b110, 0, ev(0, 1, 0, 0, 1, 4'd0));
    vec("f_bad2", 0, 3'b110, 0, ev(0, 1, 0, 0, 1, 4'd0));
    vec_n("f_red_steady", 3, 0, R, 0, s_idle);
    vec("f_yellow", 0, Y, 0, s_idle);
    vec("f_red_norq", 0, R, 0, s_idle);
    vec("f_green", 0, G, 0, s_idle);

    // Invalid code keeps a pending request.
    vec("g_press", 0, G, 1, s_req);
    vec("g_bad", 0, 3'b000, 0, ev(0, 1, 0, 1, 1, 4'd0));
    vec("g_ok", 0, G, 0, s_req);
    vec("g_walk5", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd5));
    vec("g_walk4", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd4));
    vec("g_walk3", 0, R, 0, ev(1, 0, 0, 0, 0, 4'd3));
    vec("g_flash2", 0, R, 0, ev(0, 1, 1, 0, 0, 4'd2));
    vec("g_flash_press", 0, R, 1, ev(0, 0, 1, 1, 0, 4'd1));

    // Reset mid-FLASH drops the pending request.
    vec("h_reset", 1, R, 1, s_idle);
    vec("h_after_reset", 0, R, 0, s_idle);
    vec("h_green", 0, G, 0, s_idle);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ped_crossing_controller.md
Name: ped_crossing_controller

Overview:
- Downstream stage of the traffic light FSM. Consumes its one-hot `light[2:0]` bus (`[2]`=Red, `[1]`=Yellow, `[0]`=Green) and a pedestrian push-button.
- Produces pedestrian WALK / DON'T-WALK signalling, granted only inside a vehicle RED phase.
- Latches button requests, serves each one at the next RED entry, and aborts to DON'T-WALK the moment vehicle RED ends.

Parameters:
- WALK_CYCLES, 3, number of cycles walk is asserted per crossing (min 1).
- FLASH_CYCLES, 2, number of cycles of flashing dont_walk after walk (min 1); WALK_CYCLES+FLASH_CYCLES must be <= 15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- light  input  3  vehicle light bus from the controller; valid codes are 100, 010 and 001.
- ped_btn  input  1  pedestrian button, already synchronous to clk; level, may be held for many cycles.
- walk  output  1  pedestrian WALK lamp.
- dont_walk  output  1  pedestrian DON'T-WALK lamp (blinks in FLASH).
- flash  output  1  high while in FLASH state.
- req_pending  output  1  latched, not-yet-served crossing request.
- countdown  output  4  cycles remaining in the current crossing, including the present cycle; 0 when idle.
- fault  output  1  registered flag; high the cycle after an invalid light code is sampled.

Behaviour:
- Reset is synchronous: on a rising clk edge with rst=1, all registers clear.
  - State = STOP; light_q = 000; btn_q = 0.
  - Outputs: walk=0, dont_walk=1, flash=0, req_pending=0, countdown=0, fault=0.
  - rst asserted mid-crossing (WALK or FLASH) returns to STOP on that edge and drops any pending request.
- Edge detection:
  - light_q registers light each cycle; red_rise = (light==100) && (light_q!=100).
  - btn_q registers ped_btn; btn_rise = ped_btn && !btn_q.
  - One held press produces exactly one request.
- Request latch: req_pending sets on btn_rise and clears on the edge that enters WALK. If btn_rise and WALK entry happen in the same cycle, the press is consumed by that crossing and req_pending stays 0.
- Invalid light (not one of 100/010/001, e.g. 000, 110, 111):
  - fault=1 on the next cycle; fault follows the sampled validity each cycle and is not sticky.
  - State is forced to STOP on the same edge.
  - req_pending is retained.
- States and outputs (Moore; outputs decoded from registered state and counter):
  - STOP: walk=0, dont_walk=1, flash=0.
    - Moves to WALK when red_rise && (req_pending || btn_rise) && light is valid.
    - Counter loads WALK_CYCLES+FLASH_CYCLES.
  - WALK: walk=1, dont_walk=0, flash=0.
    - Lasts exactly WALK_CYCLES cycles, then goes to FLASH.
  - FLASH: walk=0, flash=1.
    - dont_walk=1 on the first FLASH cycle, then toggles every cycle.
    - Lasts exactly FLASH_CYCLES cycles, then goes to STOP.
  - Abort: in WALK or FLASH, if the sampled light != 100, the next state is STOP. Pedestrian safety overrides the timing.
- Latency: red_rise sampled at the cycle-N edge gives walk=1 from cycle N+1.
- countdown:
  - Equals WALK_CYCLES+FLASH_CYCLES in the first WALK cycle.
  - Decrements by 1 each cycle; it is 1 in the last FLASH cycle and 0 in STOP.
  - It never wraps; abort forces it to 0.
- A button press during WALK or FLASH sets req_pending. That request is served at the next red_rise, never by re-triggering within the same RED phase.
- RED held continuously after a crossing completes does not start a second crossing; red_rise is required.
- At most one state transition per cycle. Precedence: rst > invalid light > abort > timer expiry > request start.

Test Plan:
- Reset, then 3 idle cycles with light=001, ped_btn=0 -> walk=0, dont_walk=1, flash=0, req_pending=0, countdown=0, fault=0.
- Defaults; pulse ped_btn at cycle 2; light goes 001→100 at cycle 10 and holds 6 cycles:
  - req_pending=1 over cycles 3–10 and 0 from 11.
  - walk=1 in cycles 11–13 with countdown 5,4,3.
  - FLASH in cycles 14–15 with dont_walk 1,0 and countdown 2,1.
  - STOP at cycle 16 with dont_walk=1 and countdown=0.
- ped_btn held high for 20 cycles spanning two RED phases -> exactly one crossing, in the first RED only; req_pending=0 afterwards.
- Crossing in WALK (countdown=4), light forced to 001 -> next cycle walk=0, dont_walk=1, flash=0, countdown=0.
- Press during FLASH -> req_pending=1 stays set through GREEN and YELLOW, and the crossing starts on the cycle after the next red_rise.
- light=110 for 2 cycles mid-WALK -> fault=1 for those 2 cycles (one-cycle lag) and STOP; then light=100 steady -> no new crossing until the next red_rise. Separately, rst=1 mid-FLASH -> all reset values on the next edge.
